// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the pipeline registers and the hazard unit.
// The pipeline side drives instruction/register info; the hazard unit drives the control outputs.
interface hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // Pipeline-side inputs
  logic                  branch_id;
  logic                  pc_src_id;
  logic                  md_start_id;
  logic                  md_use_id;
  logic [REG_ADDR_W-1:0] rs_id;
  logic [REG_ADDR_W-1:0] rt_id;
  logic [REG_ADDR_W-1:0] rs_ex;
  logic [REG_ADDR_W-1:0] rt_ex;
  logic [REG_ADDR_W-1:0] write_reg_ex;
  logic [REG_ADDR_W-1:0] write_reg_mem;
  logic [REG_ADDR_W-1:0] write_reg_wb;
  logic                  mem_to_reg_ex;
  logic                  mem_to_reg_mem;
  logic                  reg_write_ex;
  logic                  reg_write_mem;
  logic                  reg_write_wb;
  logic                  clr_stats;

  // Hazard-unit outputs
  logic                  stall_if;
  logic                  stall_id;
  logic                  flush_ex;
  logic                  flush_id;
  logic                  forward_a_id;
  logic                  forward_b_id;
  logic [1:0]            forward_a_ex;
  logic [1:0]            forward_b_ex;
  logic                  md_busy;
  logic [CNT_W-1:0]      stall_count;

  // Pipeline side: drives instruction info, receives controls.
  modport master (
    output branch_id, pc_src_id, md_start_id, md_use_id,
    output rs_id, rt_id, rs_ex, rt_ex,
    output write_reg_ex, write_reg_mem, write_reg_wb,
    output mem_to_reg_ex, mem_to_reg_mem,
    output reg_write_ex, reg_write_mem, reg_write_wb,
    output clr_stats,
    input  stall_if, stall_id, flush_ex, flush_id,
    input  forward_a_id, forward_b_id, forward_a_ex, forward_b_ex,
    input  md_busy, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  branch_id, pc_src_id, md_start_id, md_use_id,
    input  rs_id, rt_id, rs_ex, rt_ex,
    input  write_reg_ex, write_reg_mem, write_reg_wb,
    input  mem_to_reg_ex, mem_to_reg_mem,
    input  reg_write_ex, reg_write_mem, reg_write_wb,
    input  clr_stats,
    output stall_if, stall_id, flush_ex, flush_id,
    output forward_a_id, forward_b_id, forward_a_ex, forward_b_ex,
    output md_busy, stall_count
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// 5-stage MIPS hazard unit: forwarding selects, stall/flush generation,
// multi-cycle mult/div busy tracking and a saturating stall counter.
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter bit FWD_ENABLE = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hazard_unit_mc_if.slave   hz
);

  localparam logic [7:0]       MD_LOAD = 8'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A destination hits only if it is written and is not r0.
  function automatic logic hit(input logic en,
                               input logic [REG_ADDR_W-1:0] dst,
                               input logic [REG_ADDR_W-1:0] src);
    return en && (dst != '0) && (dst == src);
  endfunction

  logic             mem_hit_rs_ex, mem_hit_rt_ex;
  logic             wb_hit_rs_ex,  wb_hit_rt_ex;
  logic             mem_hit_rs_id, mem_hit_rt_id;
  logic             lw_stall, br_stall, raw_stall, md_stall;
  logic             stall;

  logic [7:0]       md_cnt_q, md_cnt_d;
  logic             md_busy_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // ------------------------------------------------------------------
  // Forwarding
  // ------------------------------------------------------------------
  always_comb begin
    mem_hit_rs_ex = hit(hz.reg_write_mem, hz.write_reg_mem, hz.rs_ex);
    mem_hit_rt_ex = hit(hz.reg_write_mem, hz.write_reg_mem, hz.rt_ex);
    wb_hit_rs_ex  = hit(hz.reg_write_wb,  hz.write_reg_wb,  hz.rs_ex);
    wb_hit_rt_ex  = hit(hz.reg_write_wb,  hz.write_reg_wb,  hz.rt_ex);
    mem_hit_rs_id = hit(hz.reg_write_mem, hz.write_reg_mem, hz.rs_id);
    mem_hit_rt_id = hit(hz.reg_write_mem, hz.write_reg_mem, hz.rt_id);
  end

  always_comb begin
    hz.forward_a_ex = 2'b00;
    hz.forward_b_ex = 2'b00;
    hz.forward_a_id = 1'b0;
    hz.forward_b_id = 1'b0;
    if (FWD_ENABLE) begin
      // MEM holds the younger result, so it wins over WB.
      if (mem_hit_rs_ex)     hz.forward_a_ex = 2'b10;
      else if (wb_hit_rs_ex) hz.forward_a_ex = 2'b01;
      if (mem_hit_rt_ex)     hz.forward_b_ex = 2'b10;
      else if (wb_hit_rt_ex) hz.forward_b_ex = 2'b01;
      // The register file writes in the first half-cycle, so ID only needs MEM.
      hz.forward_a_id = mem_hit_rs_id;
      hz.forward_b_id = mem_hit_rt_id;
    end
  end

  // ------------------------------------------------------------------
  // Stall conditions
  // ------------------------------------------------------------------
  always_comb begin
    lw_stall = hit(hz.mem_to_reg_ex, hz.write_reg_ex, hz.rs_id) ||
               hit(hz.mem_to_reg_ex, hz.write_reg_ex, hz.rt_id);

    br_stall = hz.branch_id &&
               (hit(hz.reg_write_ex,   hz.write_reg_ex,  hz.rs_id) ||
                hit(hz.reg_write_ex,   hz.write_reg_ex,  hz.rt_id) ||
                hit(hz.mem_to_reg_mem, hz.write_reg_mem, hz.rs_id) ||
                hit(hz.mem_to_reg_mem, hz.write_reg_mem, hz.rt_id));

    raw_stall = 1'b0;
    if (!FWD_ENABLE) begin
      raw_stall = hit(hz.reg_write_ex, hz.write_reg_ex, hz.rs_id) ||
                  hit(hz.reg_write_ex, hz.write_reg_ex, hz.rt_id) ||
                  mem_hit_rs_id || mem_hit_rt_id;
    end

    // Uses the registered busy flag only, so there is no loop through stall.
    md_stall = md_busy_q && (hz.md_use_id || hz.md_start_id);

    stall = lw_stall || br_stall || raw_stall || md_stall;
  end

  assign hz.stall_if = stall;
  assign hz.stall_id = stall;
  assign hz.flush_ex = stall;
  assign hz.flush_id = hz.pc_src_id && !stall;

  // ------------------------------------------------------------------
  // Mult/div busy tracker and stall statistics
  // ------------------------------------------------------------------
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.md_start_id && !stall) begin
      md_cnt_d = MD_LOAD;
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hz.clr_stats) begin
      stall_count_d = '0;
    end else if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q      <= 8'd0;
      md_busy_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      md_cnt_q      <= md_cnt_d;
      md_busy_q     <= (md_cnt_d != 8'd0);
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.md_busy     = md_busy_q;
  assign hz.stall_count = stall_count_q;

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the 5-stage MIPS hazard unit. Sits beside the ID/EX/MEM/WB pipeline registers.
- Generates forwarding selects, stall and flush controls, and a branch-taken IF/ID flush.
- Adds a register-0 exclusion and a no-forwarding mode.
- Adds a multi-cycle multiply/divide busy tracker and a saturating stall-cycle counter for debug readout.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- MD_LATENCY, 4, cycles the mult/div unit is busy after issue (1..255).
- FWD_ENABLE, 1, 1 = forward from MEM/WB; 0 = resolve every RAW hazard by stalling.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- branch_id  in  1  ID instruction is a branch.
- pc_src_id  in  1  branch/jump resolved taken in ID.
- md_start_id  in  1  ID instruction is mult/div.
- md_use_id  in  1  ID instruction reads HI/LO (mfhi/mflo).
- rs_id, rt_id  in  REG_ADDR_W  ID source registers.
- rs_ex, rt_ex  in  REG_ADDR_W  EX source registers.
- write_reg_ex, write_reg_mem, write_reg_wb  in  REG_ADDR_W  destination registers.
- mem_to_reg_ex, mem_to_reg_mem  in  1  load in EX / MEM.
- reg_write_ex, reg_write_mem, reg_write_wb  in  1  register write enables.
- clr_stats  in  1  synchronous clear of stall_count.
- stall_if, stall_id  out  1  hold PC and IF/ID.
- flush_ex  out  1  bubble into ID/EX.
- flush_id  out  1  squash IF/ID.
- forward_a_id, forward_b_id  out  1  ID comparator operand from MEM.
- forward_a_ex, forward_b_ex  out  2  ALU operand select: 00 regfile, 01 WB, 10 MEM.
- md_busy  out  1  mult/div in progress.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Match rule: a destination "hits" only if its enable is set and the destination is nonzero. Register 0 never forwards or stalls.
- forward_*_ex: MEM hit → 10, else WB hit → 01, else 00. MEM has priority on a simultaneous hit. Combinational.
- forward_*_id = MEM hit on rs_id/rt_id. The register file writes in the first half-cycle, so WB needs no ID forward.
- lw_stall: mem_to_reg_ex and write_reg_ex hits rs_id or rt_id. The destination compare uses write_reg_ex, not rt_ex.
- br_stall: branch_id and either (reg_write_ex hit on rs_id/rt_id) or (mem_to_reg_mem hit on rs_id/rt_id).
- raw_stall: active only when FWD_ENABLE=0. Asserted on any EX or MEM hit on rs_id/rt_id. When FWD_ENABLE=0, all forward outputs are held 0.
- md_stall: md_busy and (md_use_id or md_start_id).
- stall_id = stall_if = flush_ex = lw_stall | br_stall | raw_stall | md_stall.
- flush_id = pc_src_id & ~stall_id.
- Mult/div tracker, 8-bit md_cnt:
  - Reset: md_cnt = 0.
  - Issue (md_start_id & ~stall_id): md_cnt ← MD_LATENCY.
  - Otherwise, if md_cnt != 0: md_cnt ← md_cnt − 1.
  - md_busy = (md_cnt != 0), registered. There is no combinational path from stall_id back into md_stall.
  - A dependent mfhi arriving in ID the cycle after issue stalls exactly MD_LATENCY cycles.
  - Back-to-back mult: the second one stalls until md_cnt = 0, then issues and reloads.
- stall_count:
  - Reset: 0.
  - clr_stats wins over increment and sets the count to 0.
  - Otherwise, +1 on every cycle with stall_id = 1, saturating at all-ones with no wrap.
- Reset values: md_cnt = 0, stall_count = 0, md_busy = 0. Combinational outputs follow the inputs (all 0 for all-zero inputs).
- Reset asserted mid-busy: md_busy drops immediately (asynchronous) and no stall remains after release.

Test Plan:
- rs_ex=3, write_reg_mem=3, reg_write_mem=1, write_reg_wb=3, reg_write_wb=1 → forward_a_ex=10. Then drop reg_write_mem → 01. Then rs_ex=0 with all writes to r0 → 00.
- Load in EX (mem_to_reg_ex=1, write_reg_ex=5), rt_id=5 → stall_if=stall_id=flush_ex=1 for one cycle; stall_count increments by 1. rt_id=0 with write_reg_ex=0 → no stall.
- branch_id=1, rs_id=7, reg_write_ex=1, write_reg_ex=7 → stall. Next cycle, same destination in MEM as a non-load → no stall and forward_a_id=1. pc_src_id=1 while stalled → flush_id=0.
- MD_LATENCY=4: issue mult, then mflo in ID (md_use_id=1) → stall_id high exactly 4 cycles, md_busy falls in the same cycle stall releases; stall_count=4.
- FWD_ENABLE=0: write_reg_mem=9 hit on rs_id=9 → stall_id=1 and forward_a_ex=00. stall_count held at all-ones under continued stall → no wrap. clr_stats=1 → 0.
- reset_n pulsed low while md_busy=1 → md_busy=0 and stall_count=0 asynchronously; after release, mflo in ID → no stall.
